// File: rtl/daq_frame_pkg.sv
// Shared definitions for the DAQ packet receiver: FSM states, trailer words,
// serial-flag windows and the CRC-15 single-word step.
package daq_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PAYLOAD,
        ST_CRC,
        ST_TRL0,
        ST_TRL1,
        ST_TRL2,
        ST_DONE
    } rx_state_t;

    localparam logic [15:0] TRL0_WORD   = 16'h700C;
    localparam logic [15:0] TRL2_WORD   = 16'h7FFF;
    localparam logic [3:0]  TRL1_NIBBLE = 4'h7;

    localparam logic [6:0] PHS_FIRST  = 7'd72;
    localparam logic [6:0] PHS_LAST   = 7'd77;
    localparam logic [6:0] SMAX_FIRST = 7'd90;
    localparam logic [6:0] SMAX_LAST  = 7'd95;

    // Same step the transmitter uses; d[12] is always 0 for payload words.
    function automatic logic [14:0] crc15_d13(input logic [12:0] d, input logic [14:0] c);
        logic [14:0] n;
        n[0] = d[0] ^ c[2];
        for (int i = 1; i <= 12; i++) begin
            n[i] = d[i-1] ^ d[i] ^ c[i+1] ^ c[i+2];
        end
        n[13] = d[12] ^ c[14] ^ c[0];
        n[14] = c[1];
        return n;
    endfunction

endpackage

// File: rtl/daq_frame_crc15.sv
// Registered CRC-15 accumulator; i_clr together with i_ce restarts the
// sequence from zero with the current word.
module daq_frame_crc15
    import daq_frame_pkg::*;
(
    input  logic        CMSCLK,
    input  logic        RST,
    input  logic        i_clr,
    input  logic        i_ce,
    input  logic [12:0] i_d,
    output logic [14:0] o_crc
);

    logic [14:0] r_crc;

    always_ff @(posedge CMSCLK or posedge RST) begin
        if (RST) begin
            r_crc <= '0;
        end else if (i_ce) begin
            r_crc <= crc15_d13(i_d, i_clr ? 15'd0 : r_crc);
        end else if (i_clr) begin
            r_crc <= '0;
        end
    end

    assign o_crc = r_crc;

endmodule

// File: rtl/daq_frame_rx.sv
// DAQ packet receiver: delineates packets, decodes L1A/samples/serial flags,
// checks CRC and trailer, and keeps saturating good/bad packet counters.
//   state   | meaning
//   IDLE    | waiting for w0 (consumed on entry)
//   PAYLOAD | w1..w(P-1): L1A low word and samples
//   CRC     | wP, received CRC word
//   TRL0    | fixed 0x700C word
//   TRL1    | L1A echo, buffer depth, warn
//   TRL2    | fixed 0x7FFF word
//   DONE    | one-cycle status/PKT_DONE, also reached on gap timeout
module daq_frame_rx
    import daq_frame_pkg::*;
#(
    parameter int PAYLOAD_WORDS = 96,
    parameter int TMO_CYCLES    = 16
) (
    input  logic        CMSCLK,
    input  logic        RST,
    input  logic [15:0] RXD,
    input  logic        RXD_VLD,
    output logic [11:0] SMP_DATA,
    output logic        SMP_VLD,
    output logic [6:0]  SMP_IDX,
    output logic [23:0] L1A_NUM,
    output logic        L1A_PHS,
    output logic        SMAX15,
    output logic [4:0]  BUF_DEPTH,
    output logic        WARN,
    output logic        PKT_DONE,
    output logic        CRC_ERR,
    output logic        FMT_ERR,
    output logic        TMO_ERR,
    output logic [15:0] PKT_CNT,
    output logic [15:0] ERR_CNT
);

    localparam int              TW       = $clog2(TMO_CYCLES + 1);
    localparam logic [6:0]      LAST_PAY = 7'(PAYLOAD_WORDS - 1);
    localparam logic [TW-1:0]   TMO_LOAD = TW'(TMO_CYCLES - 1);

    rx_state_t     r_state, w_next;
    logic [6:0]    r_wcnt;
    logic [TW-1:0] r_tmo;
    logic [23:0]   r_l1a;
    logic          r_phs, r_smax, r_warn;
    logic [4:0]    r_buf;
    logic [11:0]   r_smp_data;
    logic          r_smp_vld;
    logic [6:0]    r_smp_idx;
    logic          r_fmt, r_crc_bad, r_drop;
    logic          r_crc_err, r_fmt_err, r_tmo_err;
    logic [15:0]   r_pkt_cnt, r_err_cnt;

    logic          w_in_pkt, w_tmo_hit, w_done_entry, w_pkt_ok;
    logic          w_fmt_now, w_fmt_acc, w_sample, w_in_phs, w_in_smax;
    logic          w_crc_clr, w_crc_ce;
    logic [14:0]   w_crc;

    assign w_in_pkt  = (r_state == ST_PAYLOAD) || (r_state == ST_CRC) || (r_state == ST_TRL0)
                    || (r_state == ST_TRL1) || (r_state == ST_TRL2);
    assign w_tmo_hit = w_in_pkt && !RXD_VLD && (r_tmo == '0);
    assign w_crc_clr = (r_state == ST_IDLE) && RXD_VLD;
    assign w_crc_ce  = RXD_VLD && ((r_state == ST_IDLE) || (r_state == ST_PAYLOAD));
    assign w_sample  = (r_state == ST_PAYLOAD) && (r_wcnt != 7'd1);
    assign w_in_phs  = (r_wcnt > PHS_FIRST) && (r_wcnt <= PHS_LAST);
    assign w_in_smax = (r_wcnt > SMAX_FIRST) && (r_wcnt <= SMAX_LAST);

    daq_frame_crc15 u_crc (
        .CMSCLK (CMSCLK),
        .RST    (RST),
        .i_clr  (w_crc_clr),
        .i_ce   (w_crc_ce),
        .i_d    ({1'b0, RXD[11:0]}),
        .o_crc  (w_crc)
    );

    always_ff @(posedge CMSCLK or posedge RST) begin
        if (RST) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (RXD_VLD) w_next = ST_PAYLOAD;
            ST_PAYLOAD: if (RXD_VLD && (r_wcnt == LAST_PAY)) w_next = ST_CRC;
            ST_CRC:     if (RXD_VLD) w_next = ST_TRL0;
            ST_TRL0:    if (RXD_VLD) w_next = ST_TRL1;
            ST_TRL1:    if (RXD_VLD) w_next = ST_TRL2;
            ST_TRL2:    if (RXD_VLD) w_next = ST_DONE;
            ST_DONE:    w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
        if (w_tmo_hit) w_next = ST_DONE;
    end

    // Format violations contributed by the word being consumed this cycle.
    always_comb begin
        w_fmt_now = 1'b0;
        if (RXD_VLD) begin
            case (r_state)
                ST_IDLE:    w_fmt_now = (RXD[15:12] != 4'h0);
                ST_PAYLOAD: begin
                    if (!w_sample) begin
                        w_fmt_now = (RXD[15:12] != 4'h0);
                    end else begin
                        w_fmt_now = ({RXD[15], RXD[14], RXD[12]} != 3'b010)
                                 || (w_in_phs && (RXD[13] != r_phs))
                                 || (w_in_smax && (RXD[13] != r_smax));
                    end
                end
                ST_TRL0:    w_fmt_now = (RXD != TRL0_WORD);
                ST_TRL1:    w_fmt_now = (RXD[15:12] != TRL1_NIBBLE) || (RXD[11:6] != r_l1a[5:0]);
                ST_TRL2:    w_fmt_now = (RXD != TRL2_WORD);
                default:    w_fmt_now = 1'b0;
            endcase
        end
    end

    assign w_fmt_acc    = r_fmt | w_fmt_now;
    assign w_done_entry = (r_state != ST_DONE) && (w_next == ST_DONE);
    assign w_pkt_ok     = !r_crc_bad && !w_fmt_acc && !w_tmo_hit;

    always_ff @(posedge CMSCLK or posedge RST) begin
        if (RST) begin
            r_wcnt     <= '0;
            r_tmo      <= TMO_LOAD;
            r_l1a      <= '0;
            r_phs      <= 1'b0;
            r_smax     <= 1'b0;
            r_buf      <= '0;
            r_warn     <= 1'b0;
            r_smp_data <= '0;
            r_smp_vld  <= 1'b0;
            r_smp_idx  <= '0;
            r_fmt      <= 1'b0;
            r_crc_bad  <= 1'b0;
            r_drop     <= 1'b0;
            r_crc_err  <= 1'b0;
            r_fmt_err  <= 1'b0;
            r_tmo_err  <= 1'b0;
            r_pkt_cnt  <= '0;
            r_err_cnt  <= '0;
        end else begin
            r_smp_vld <= 1'b0;
            if (!w_in_pkt || RXD_VLD) r_tmo <= TMO_LOAD;
            else if (r_tmo != '0)     r_tmo <= r_tmo - 1'b1;

            if (RXD_VLD) begin
                case (r_state)
                    ST_IDLE: begin
                        r_l1a[23:12] <= RXD[11:0];
                        r_fmt        <= r_drop | w_fmt_now;
                        r_crc_bad    <= 1'b0;
                        r_drop       <= 1'b0;
                        r_wcnt       <= 7'd1;
                    end
                    ST_PAYLOAD: begin
                        r_fmt  <= w_fmt_acc;
                        r_wcnt <= r_wcnt + 7'd1;
                        if (!w_sample) begin
                            r_l1a[11:0] <= RXD[11:0];
                        end else begin
                            r_smp_data <= RXD[11:0];
                            r_smp_vld  <= 1'b1;
                            r_smp_idx  <= r_wcnt - 7'd2;
                            if (r_wcnt == PHS_FIRST)  r_phs  <= RXD[13];
                            if (r_wcnt == SMAX_FIRST) r_smax <= RXD[13];
                        end
                    end
                    ST_CRC:  r_crc_bad <= RXD[15] | (RXD[14:0] != w_crc);
                    ST_TRL1: begin
                        r_fmt  <= w_fmt_acc;
                        r_buf  <= RXD[5:1];
                        r_warn <= RXD[0];
                    end
                    ST_TRL0, ST_TRL2: r_fmt <= w_fmt_acc;
                    ST_DONE: r_drop <= 1'b1;
                    default: r_drop <= r_drop;
                endcase
            end

            if (w_done_entry) begin
                r_crc_err <= r_crc_bad;
                r_fmt_err <= w_fmt_acc;
                r_tmo_err <= w_tmo_hit;
                if (w_pkt_ok) begin
                    if (r_pkt_cnt != 16'hFFFF) r_pkt_cnt <= r_pkt_cnt + 16'd1;
                end else begin
                    if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
                end
            end
        end
    end

    assign SMP_DATA  = r_smp_data;
    assign SMP_VLD   = r_smp_vld;
    assign SMP_IDX   = r_smp_idx;
    assign L1A_NUM   = r_l1a;
    assign L1A_PHS   = r_phs;
    assign SMAX15    = r_smax;
    assign BUF_DEPTH = r_buf;
    assign WARN      = r_warn;
    assign PKT_DONE  = (r_state == ST_DONE);
    assign CRC_ERR   = r_crc_err;
    assign FMT_ERR   = r_fmt_err;
    assign TMO_ERR   = r_tmo_err;
    assign PKT_CNT   = r_pkt_cnt;
    assign ERR_CNT   = r_err_cnt;

endmodule

// File: tb/tb_daq_frame_rx.sv
// Scoreboard bench for daq_frame_rx: packets are built with an independent
// CRC model, expected samples/status are queued at drive time and popped by a monitor.
module tb_daq_frame_rx;

    localparam int P = 96;

    logic        CMSCLK, RST, RXD_VLD;
    logic [15:0] RXD;
    logic [11:0] SMP_DATA;
    logic        SMP_VLD;
    logic [6:0]  SMP_IDX;
    logic [23:0] L1A_NUM;
    logic        L1A_PHS, SMAX15, WARN, PKT_DONE, CRC_ERR, FMT_ERR, TMO_ERR;
    logic [4:0]  BUF_DEPTH;
    logic [15:0] PKT_CNT, ERR_CNT;

    daq_frame_rx #(.PAYLOAD_WORDS(P), .TMO_CYCLES(16)) dut (
        .CMSCLK(CMSCLK), .RST(RST), .RXD(RXD), .RXD_VLD(RXD_VLD),
        .SMP_DATA(SMP_DATA), .SMP_VLD(SMP_VLD), .SMP_IDX(SMP_IDX),
        .L1A_NUM(L1A_NUM), .L1A_PHS(L1A_PHS), .SMAX15(SMAX15),
        .BUF_DEPTH(BUF_DEPTH), .WARN(WARN), .PKT_DONE(PKT_DONE),
        .CRC_ERR(CRC_ERR), .FMT_ERR(FMT_ERR), .TMO_ERR(TMO_ERR),
        .PKT_CNT(PKT_CNT), .ERR_CNT(ERR_CNT)
    );

    initial CMSCLK = 1'b0;
    always #5 CMSCLK = ~CMSCLK;

    typedef struct {
        logic [11:0] data;
        logic [6:0]  idx;
    } smp_t;

    typedef struct {
        logic        crc, fmt, tmo, full;
        logic [23:0] l1a;
        logic        phs, smax, warn;
        logic [4:0]  bufd;
        logic [15:0] pkt, err;
    } st_t;

    smp_t        smp_q[$];
    st_t         st_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          smp_seen = 0;
    logic [15:0] exp_pkt  = 16'h0;
    logic [15:0] exp_err  = 16'h0;
    logic [15:0] pkt_w [P+4];
    logic [23:0] cur_l1a;
    logic        cur_phs, cur_smax, cur_warn;
    logic [4:0]  cur_buf;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] sat_inc(input logic [15:0] x);
        return (x == 16'hFFFF) ? x : x + 16'd1;
    endfunction

    function automatic logic [14:0] crc_step(input logic [14:0] c, input logic [11:0] w);
        logic [12:0] d;
        logic [14:0] n;
        d = {1'b0, w};
        n[0] = d[0] ^ c[2];
        for (int i = 1; i <= 12; i++) n[i] = d[i-1] ^ d[i] ^ c[i+1] ^ c[i+2];
        n[13] = d[12] ^ c[14] ^ c[0];
        n[14] = c[1];
        return n;
    endfunction

    task automatic build(input logic [23:0] l1a, input logic phs, input logic smax,
                         input logic [4:0] bufd, input logic warn, input int off);
        logic [14:0] c;
        logic        ser;
        c = 15'h0;
        pkt_w[0] = {4'h0, l1a[23:12]};
        pkt_w[1] = {4'h0, l1a[11:0]};
        for (int k = 2; k < P; k++) begin
            ser = (k >= 72 && k <= 77) ? phs : (k >= 90 && k <= 95) ? smax : 1'b0;
            pkt_w[k] = {1'b0, 1'b1, ser, 1'b0, 12'(k + off)};
        end
        for (int k = 0; k < P; k++) c = crc_step(c, pkt_w[k][11:0]);
        pkt_w[P]   = {1'b0, c};
        pkt_w[P+1] = 16'h700C;
        pkt_w[P+2] = {4'h7, l1a[5:0], bufd, warn};
        pkt_w[P+3] = 16'h7FFF;
        cur_l1a = l1a; cur_phs = phs; cur_smax = smax; cur_buf = bufd; cur_warn = warn;
    endtask

    task automatic send_word(input logic [15:0] w);
        @(negedge CMSCLK);
        RXD     = w;
        RXD_VLD = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge CMSCLK);
            RXD_VLD = 1'b0;
        end
    endtask

    // Sends the first n_words of pkt_w; fewer than P+4 words means the packet
    // is expected to end in a gap timeout.
    task automatic send_pkt(input int n_words, input int gap_at, input int gap_len,
                            input logic e_crc, input logic e_fmt, input logic e_tmo);
        st_t st;
        int  n;
        if (!e_crc && !e_fmt && !e_tmo) exp_pkt = sat_inc(exp_pkt);
        else                             exp_err = sat_inc(exp_err);
        st.crc = e_crc; st.fmt = e_fmt; st.tmo = e_tmo; st.full = (n_words == P + 4);
        st.l1a = cur_l1a; st.phs = cur_phs; st.smax = cur_smax; st.bufd = cur_buf;
        st.warn = cur_warn; st.pkt = exp_pkt; st.err = exp_err;
        st_q.push_back(st);
        for (int w = 0; w < n_words; w++) begin
            if (w == gap_at) idle(gap_len);
            if (w >= 2 && w < P) begin
                smp_t s;
                s.data = pkt_w[w][11:0];
                s.idx  = 7'(w - 2);
                smp_q.push_back(s);
            end
            send_word(pkt_w[w]);
        end
        if (n_words < P + 4) begin
            @(posedge CMSCLK);
            #1 RXD_VLD = 1'b0;
            n = 0;
            while (n < 40 && PKT_DONE !== 1'b1) begin
                @(posedge CMSCLK);
                #1 n++;
            end
            check_val("tmo_latency", n, 16);
            idle(2);
        end else begin
            idle(1);
        end
    endtask

    initial begin : monitor
        smp_t s;
        st_t  e;
        forever begin
            @(negedge CMSCLK);
            if (!RST) begin
                if (SMP_VLD) begin
                    smp_seen++;
                    if (smp_q.size() == 0) begin
                        check_val("smp_extra", 32'(SMP_VLD), 32'h0);
                    end else begin
                        s = smp_q.pop_front();
                        check_val("smp_data", 32'(SMP_DATA), 32'(s.data));
                        check_val("smp_idx", 32'(SMP_IDX), 32'(s.idx));
                    end
                end
                if (PKT_DONE) begin
                    if (st_q.size() == 0) begin
                        check_val("done_extra", 32'(PKT_DONE), 32'h0);
                    end else begin
                        e = st_q.pop_front();
                        check_val("crc_err", 32'(CRC_ERR), 32'(e.crc));
                        check_val("fmt_err", 32'(FMT_ERR), 32'(e.fmt));
                        check_val("tmo_err", 32'(TMO_ERR), 32'(e.tmo));
                        check_val("pkt_cnt", 32'(PKT_CNT), 32'(e.pkt));
                        check_val("err_cnt", 32'(ERR_CNT), 32'(e.err));
                        if (e.full) begin
                            check_val("l1a_num", 32'(L1A_NUM), 32'(e.l1a));
                            check_val("l1a_phs", 32'(L1A_PHS), 32'(e.phs));
                            check_val("smax15", 32'(SMAX15), 32'(e.smax));
                            check_val("buf_depth", 32'(BUF_DEPTH), 32'(e.bufd));
                            check_val("warn", 32'(WARN), 32'(e.warn));
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog time limit reached checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    task automatic check_all_zero(input string tag);
        check_val({tag, "_smp"}, 32'({SMP_VLD, SMP_DATA, SMP_IDX}), 32'h0);
        check_val({tag, "_l1a"}, 32'(L1A_NUM), 32'h0);
        check_val({tag, "_flags"}, 32'({L1A_PHS, SMAX15, BUF_DEPTH, WARN}), 32'h0);
        check_val({tag, "_stat"}, 32'({PKT_DONE, CRC_ERR, FMT_ERR, TMO_ERR}), 32'h0);
        check_val({tag, "_cnt"}, {PKT_CNT, ERR_CNT}, 32'h0);
    endtask

    initial begin : stim
        int base;
        RST = 1'b1; RXD = 16'h0; RXD_VLD = 1'b0;
        repeat (2) @(negedge CMSCLK);
        check_all_zero("reset");
        RST = 1'b0;
        idle(2);

        // clean packet, samples equal word index
        build(24'h123456, 1'b1, 1'b0, 5'd3, 1'b0, 0);
        base = smp_seen;
        send_pkt(P + 4, -1, 0, 1'b0, 1'b0, 1'b0);
        check_val("smp_count", smp_seen - base, 94);

        // sample bit 5 of w40 flipped, CRC word left stale
        build(24'h0AB123, 1'b0, 1'b1, 5'd7, 1'b1, 5);
        pkt_w[40] = pkt_w[40] ^ 16'h0020;
        send_pkt(P + 4, -1, 0, 1'b1, 1'b0, 1'b0);

        build(24'h123456, 1'b1, 1'b0, 5'd3, 1'b0, 9);
        pkt_w[P+1] = 16'h700D;
        send_pkt(P + 4, -1, 0, 1'b0, 1'b1, 1'b0);

        build(24'h123456, 1'b0, 1'b0, 5'd17, 1'b1, 11);
        pkt_w[P+2][11:6] = 6'h15;
        send_pkt(P + 4, -1, 0, 1'b0, 1'b1, 1'b0);

        build(24'h3C0F0A, 1'b1, 1'b1, 5'd31, 1'b0, 100);
        send_pkt(P + 4, 50, 15, 1'b0, 1'b0, 1'b0);

        // 16-cycle gap before w50 aborts, then a clean packet follows
        build(24'h3C0F0B, 1'b1, 1'b1, 5'd1, 1'b0, 200);
        send_pkt(50, -1, 0, 1'b0, 1'b0, 1'b1);
        build(24'h000777, 1'b0, 1'b1, 5'd12, 1'b1, 300);
        send_pkt(P + 4, -1, 0, 1'b0, 1'b0, 1'b0);

        build(24'h456789, 1'b1, 1'b0, 5'd4, 1'b0, 7);
        pkt_w[75][13] = ~pkt_w[75][13];
        send_pkt(P + 4, -1, 0, 1'b0, 1'b1, 1'b0);

        // back-to-back with the minimum one-cycle gap
        build(24'hABCDEF, 1'b0, 1'b0, 5'd9, 1'b1, 40);
        send_pkt(P + 4, -1, 0, 1'b0, 1'b0, 1'b0);
        build(24'h000FFF, 1'b1, 1'b1, 5'd22, 1'b0, 41);
        send_pkt(P + 4, -1, 0, 1'b0, 1'b0, 1'b0);

        // error counter saturation from a preloaded value
        @(negedge CMSCLK);
        dut.r_err_cnt = 16'hFFFE;
        exp_err = 16'hFFFE;
        repeat (3) begin
            build(24'h010203, 1'b0, 1'b0, 5'd0, 1'b0, 0);
            send_pkt(1, -1, 0, 1'b0, 1'b0, 1'b1);
        end

        // reset in the middle of a packet
        build(24'h555555, 1'b1, 1'b0, 5'd5, 1'b0, 60);
        for (int w = 0; w < 30; w++) begin
            if (w >= 2) begin
                smp_t s;
                s.data = pkt_w[w][11:0];
                s.idx  = 7'(w - 2);
                smp_q.push_back(s);
            end
            send_word(pkt_w[w]);
        end
        @(negedge CMSCLK);
        #1 RST = 1'b1;
        RXD_VLD = 1'b0;
        exp_pkt = 16'h0;
        exp_err = 16'h0;
        #1 check_all_zero("midrst");
        repeat (3) @(negedge CMSCLK);
        RST = 1'b0;
        idle(3);
        check_val("midrst_no_done", 32'(PKT_DONE), 32'h0);

        build(24'h00ABCD, 1'b0, 1'b1, 5'd6, 1'b1, 77);
        send_pkt(P + 4, -1, 0, 1'b0, 1'b0, 1'b0);

        idle(5);
        check_val("smp_q_left", smp_q.size(), 0);
        check_val("st_q_left", st_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
